// File: rtl/vta_pkg.sv
// Shared VTA definitions: opcodes, memory-instruction layout and decode.
// Used by the store-side sequencer and its row address generator.
package vta_pkg;

    typedef enum logic [2:0] {
        LOAD   = 3'd0,
        STORE  = 3'd1,
        GEMM   = 3'd2,
        FINISH = 3'd3,
        ALU    = 3'd4
    } opcode_e;

    localparam int INSN_W      = 128;
    localparam int OPC_LSB     = 0;
    localparam int OPC_W       = 3;
    localparam int POP_PREV    = 3;
    localparam int POP_NEXT    = 4;
    localparam int PUSH_PREV   = 5;
    localparam int PUSH_NEXT   = 6;
    localparam int SRAM_LSB    = 9;
    localparam int SRAM_W      = 16;
    localparam int DRAM_LSB    = 25;
    localparam int DRAM_W      = 32;
    localparam int YSIZE_LSB   = 64;
    localparam int XSIZE_LSB   = 80;
    localparam int XSTRIDE_LSB = 96;
    localparam int SIZE_W      = 16;

    typedef struct packed {
        logic [15:0]       pad;
        logic [SIZE_W-1:0] x_stride;
        logic [SIZE_W-1:0] x_size;
        logic [SIZE_W-1:0] y_size;
        logic [6:0]        rsvd_hi;
        logic [DRAM_W-1:0] dram_base;
        logic [SRAM_W-1:0] sram_base;
        logic [1:0]        rsvd_lo;
        logic              push_next;
        logic              push_prev;
        logic              pop_next;
        logic              pop_prev;
        logic [OPC_W-1:0]  opcode;
    } mem_insn_t;

    function automatic mem_insn_t insn_decode(logic [INSN_W-1:0] w);
        mem_insn_t i;
        i           = '0;
        i.opcode    = w[OPC_LSB +: OPC_W];
        i.pop_prev  = w[POP_PREV];
        i.pop_next  = w[POP_NEXT];
        i.push_prev = w[PUSH_PREV];
        i.push_next = w[PUSH_NEXT];
        i.sram_base = w[SRAM_LSB +: SRAM_W];
        i.dram_base = w[DRAM_LSB +: DRAM_W];
        i.y_size    = w[YSIZE_LSB +: SIZE_W];
        i.x_size    = w[XSIZE_LSB +: SIZE_W];
        i.x_stride  = w[XSTRIDE_LSB +: SIZE_W];
        return i;
    endfunction

endpackage

// File: rtl/store_insn_sequencer_if.sv
// Store-queue, dependency-token and row-command bundle of the store sequencer.
// slave is the sequencer's view, master the surrounding system's.
interface store_insn_sequencer_if;
    import vta_pkg::*;

    logic [INSN_W-1:0] store_queue_V_V_TDATA;
    logic              store_queue_V_V_TVALID;
    logic              store_queue_V_V_TREADY;
    logic              g2s_dep_TVALID;
    logic              g2s_dep_TREADY;
    logic              s2g_dep_TVALID;
    logic              s2g_dep_TREADY;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [15:0]       cmd_sram_addr;
    logic [31:0]       cmd_dram_addr;
    logic [15:0]       cmd_len;
    logic              wr_done;

    modport slave (
        input  store_queue_V_V_TDATA,
        input  store_queue_V_V_TVALID,
        output store_queue_V_V_TREADY,
        input  g2s_dep_TVALID,
        output g2s_dep_TREADY,
        output s2g_dep_TVALID,
        input  s2g_dep_TREADY,
        output cmd_valid,
        input  cmd_ready,
        output cmd_sram_addr,
        output cmd_dram_addr,
        output cmd_len,
        input  wr_done
    );

    modport master (
        output store_queue_V_V_TDATA,
        output store_queue_V_V_TVALID,
        input  store_queue_V_V_TREADY,
        output g2s_dep_TVALID,
        input  g2s_dep_TREADY,
        input  s2g_dep_TVALID,
        output s2g_dep_TREADY,
        input  cmd_valid,
        output cmd_ready,
        input  cmd_sram_addr,
        input  cmd_dram_addr,
        input  cmd_len,
        output wr_done
    );

endinterface

// File: rtl/store_row_gen.sv
// Row counter plus running SRAM/DRAM address accumulators for one
// store instruction; advances by x_size and x_stride*OUT_ELEM_BYTES.
module store_row_gen #(
    parameter int OUT_ELEM_BYTES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        advance_i,
    input  logic [15:0] sram_base_i,
    input  logic [31:0] dram_base_i,
    input  logic [15:0] y_size_i,
    input  logic [15:0] x_size_i,
    input  logic [15:0] x_stride_i,
    output logic [15:0] sram_addr_o,
    output logic [31:0] dram_addr_o,
    output logic [15:0] len_o,
    output logic        last_o
);
    localparam int SHIFT = $clog2(OUT_ELEM_BYTES);

    logic [15:0] row_q;
    logic [15:0] y_q;
    logic [15:0] x_q;
    logic [15:0] sram_q;
    logic [31:0] dram_q;
    logic [31:0] dstep_q;

    // Byte scaling is a shift: element size is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            row_q   <= '0;
            y_q     <= '0;
            x_q     <= '0;
            sram_q  <= '0;
            dram_q  <= '0;
            dstep_q <= '0;
        end else if (load_i) begin
            row_q   <= '0;
            y_q     <= y_size_i;
            x_q     <= x_size_i;
            sram_q  <= sram_base_i;
            dram_q  <= dram_base_i << SHIFT;
            dstep_q <= {16'b0, x_stride_i} << SHIFT;
        end else if (advance_i) begin
            row_q   <= row_q + 16'd1;
            sram_q  <= sram_q + x_q;
            dram_q  <= dram_q + dstep_q;
        end
    end

    assign sram_addr_o = sram_q;
    assign dram_addr_o = dram_q;
    assign len_o       = x_q;
    assign last_o      = (row_q == y_q - 16'd1);

endmodule

// File: rtl/store_insn_sequencer.sv
// Store-stage sequencer: pops STORE instructions, honours g2s/s2g tokens
// and expands each instruction into one write command per output row.
module store_insn_sequencer
    import vta_pkg::*;
#(
    parameter int OUT_ELEM_BYTES = 16,
    parameter int CNT_W          = 32
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    store_insn_sequencer_if.slave  bus,
    output logic                   busy,
    output logic [CNT_W-1:0]       retired_cnt
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_DEP,
        S_ISSUE,
        S_WAIT_DONE,
        S_PUSH
    } state_e;

    state_e           state_q;
    logic             tready_q;
    logic             g2s_rdy_q;
    logic             s2g_vld_q;
    logic             cmd_vld_q;
    logic             busy_q;
    logic             push_q;
    logic [15:0]      rows_q;
    logic [15:0]      done_q;
    logic [15:0]      done_d;
    logic [CNT_W-1:0] ret_q;

    mem_insn_t insn_w;
    logic      has_rows;
    logic      q_hs;
    logic      g2s_hs;
    logic      s2g_hs;
    logic      cmd_hs;
    logic      last_row;
    logic      unused_bits;

    assign insn_w   = insn_decode(bus.store_queue_V_V_TDATA);
    assign has_rows = (insn_w.opcode == 3'(STORE))
                   && (insn_w.y_size != '0)
                   && (insn_w.x_size != '0);
    // Pad, reserved and next-stage token bits have no meaning for store.
    assign unused_bits = ^{insn_w, bus.store_queue_V_V_TDATA};

    assign q_hs   = (state_q == S_IDLE) && tready_q
                 && bus.store_queue_V_V_TVALID;
    assign g2s_hs = g2s_rdy_q && bus.g2s_dep_TVALID;
    assign s2g_hs = s2g_vld_q && bus.s2g_dep_TREADY;
    assign cmd_hs = cmd_vld_q && bus.cmd_ready;
    assign done_d = done_q + {15'b0, bus.wr_done};

    store_row_gen #(
        .OUT_ELEM_BYTES(OUT_ELEM_BYTES)
    ) u_rows (
        .clk_i       (ap_clk),
        .rst_i       (ap_rst),
        .load_i      (q_hs),
        .advance_i   (cmd_hs),
        .sram_base_i (insn_w.sram_base),
        .dram_base_i (insn_w.dram_base),
        .y_size_i    (insn_w.y_size),
        .x_size_i    (insn_w.x_size),
        .x_stride_i  (insn_w.x_stride),
        .sram_addr_o (bus.cmd_sram_addr),
        .dram_addr_o (bus.cmd_dram_addr),
        .len_o       (bus.cmd_len),
        .last_o      (last_row)
    );

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q   <= S_IDLE;
            tready_q  <= 1'b1;
            g2s_rdy_q <= 1'b0;
            s2g_vld_q <= 1'b0;
            cmd_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            push_q    <= 1'b0;
            rows_q    <= '0;
            done_q    <= '0;
            ret_q     <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (q_hs) begin
                        tready_q <= 1'b0;
                        busy_q   <= 1'b1;
                        push_q   <= insn_w.push_prev;
                        rows_q   <= has_rows ? insn_w.y_size : 16'd0;
                        done_q   <= '0;
                        if (insn_w.pop_prev) begin
                            state_q   <= S_WAIT_DEP;
                            g2s_rdy_q <= 1'b1;
                        end else begin
                            state_q   <= S_ISSUE;
                            cmd_vld_q <= has_rows;
                        end
                    end
                end
                S_WAIT_DEP: begin
                    if (g2s_hs) begin
                        g2s_rdy_q <= 1'b0;
                        state_q   <= S_ISSUE;
                        cmd_vld_q <= (rows_q != '0);
                    end
                end
                S_ISSUE: begin
                    done_q <= done_d;
                    if (rows_q == '0) begin
                        state_q <= S_WAIT_DONE;
                    end else if (cmd_hs && last_row) begin
                        cmd_vld_q <= 1'b0;
                        state_q   <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    done_q <= done_d;
                    if (done_d == rows_q) begin
                        if (push_q) begin
                            s2g_vld_q <= 1'b1;
                            state_q   <= S_PUSH;
                        end else begin
                            ret_q    <= ret_q + CNT_W'(1);
                            tready_q <= 1'b1;
                            busy_q   <= 1'b0;
                            state_q  <= S_IDLE;
                        end
                    end
                end
                S_PUSH: begin
                    if (s2g_hs) begin
                        s2g_vld_q <= 1'b0;
                        ret_q     <= ret_q + CNT_W'(1);
                        tready_q  <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.store_queue_V_V_TREADY = tready_q;
    assign bus.g2s_dep_TREADY         = g2s_rdy_q;
    assign bus.s2g_dep_TVALID         = s2g_vld_q;
    assign bus.cmd_valid              = cmd_vld_q;
    assign busy                       = busy_q;
    assign retired_cnt                = ret_q;

endmodule

// File: tb/tb_store_insn_sequencer.sv
// Directed plus randomized bench for store_insn_sequencer; expected row
// commands come from direct address arithmetic on the instruction fields.
module tb_store_insn_sequencer;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        busy;
    logic [31:0] retired_cnt;

    store_insn_sequencer_if bus ();

    store_insn_sequencer #(
        .OUT_ELEM_BYTES(16),
        .CNT_W(32)
    ) dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .bus         (bus),
        .busy        (busy),
        .retired_cnt (retired_cnt)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct packed {
        logic [15:0] s;
        logic [31:0] d;
        logic [15:0] l;
    } cmd_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    cmd_t got_q[$];
    cmd_t exp_q[$];
    int   due_q[$];
    int   last_due;
    int   rdy_mode;
    int   dmin;
    int   dmax;
    bit   s2g_rand;
    int   q_hs_cyc;
    int   g2s_hs_cyc;
    int   first_cmd_cyc;
    int   s2g_rise_cyc;
    int   last_done_cyc;
    int   retire_cyc;
    int   n_g2s;
    int   n_s2g;
    int   stab_err;
    int   busy_err;
    bit   prev_stall;
    cmd_t prev_cmd;
    bit   q_sent;
    bit   g2s_taken;
    logic [31:0] exp_ret;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("%s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: drives and samples for the next rising edge.
    task automatic cycle();
        cmd_t c;
        int   due;
        if (rdy_mode == 0) bus.cmd_ready = 1'b1;
        else if (rdy_mode == 1) bus.cmd_ready = 1'($urandom_range(0, 1));
        else bus.cmd_ready = 1'b0;
        bus.s2g_dep_TREADY = s2g_rand ? 1'($urandom_range(0, 2) == 0) : 1'b1;
        bus.wr_done = 1'b0;
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
            bus.wr_done = 1'b1;
            void'(due_q.pop_front());
            last_done_cyc = cyc;
        end
        c = '{bus.cmd_sram_addr, bus.cmd_dram_addr, bus.cmd_len};
        if (prev_stall && (!bus.cmd_valid || c != prev_cmd)) stab_err++;
        prev_stall = bus.cmd_valid && !bus.cmd_ready;
        prev_cmd   = c;
        if (bus.cmd_valid && first_cmd_cyc < 0) first_cmd_cyc = cyc;
        if (bus.cmd_valid && bus.cmd_ready) begin
            got_q.push_back(c);
            due = cyc + int'($urandom_range(dmin, dmax));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            due_q.push_back(due);
        end
        if (bus.store_queue_V_V_TVALID && bus.store_queue_V_V_TREADY) begin
            q_hs_cyc = cyc;
            q_sent   = 1'b1;
        end
        if (bus.g2s_dep_TVALID && bus.g2s_dep_TREADY) begin
            n_g2s++;
            g2s_hs_cyc = cyc;
            g2s_taken  = 1'b1;
        end
        if (bus.s2g_dep_TVALID && s2g_rise_cyc < 0) s2g_rise_cyc = cyc;
        if (bus.s2g_dep_TVALID && bus.s2g_dep_TREADY) n_s2g++;
        if (bus.store_queue_V_V_TREADY && busy) busy_err++;
        @(negedge ap_clk);
        cyc++;
        if (q_sent) begin
            bus.store_queue_V_V_TVALID = 1'b0;
            q_sent = 1'b0;
        end
        if (g2s_taken) begin
            bus.g2s_dep_TVALID = 1'b0;
            g2s_taken = 1'b0;
        end
    endtask

    function automatic logic [127:0] mk_insn(logic [2:0] op, bit pop, bit push,
                                             logic [15:0] sb, logic [31:0] db,
                                             logic [15:0] y, logic [15:0] x,
                                             logic [15:0] st);
        logic [127:0] w;
        w = {$urandom, $urandom, $urandom, $urandom};
        w[2:0]     = op;
        w[3]       = pop;
        w[5]       = push;
        w[24:9]    = sb;
        w[56:25]   = db;
        w[79:64]   = y;
        w[95:80]   = x;
        w[111:96]  = st;
        return w;
    endfunction

    task automatic clear_obs();
        got_q.delete();
        n_g2s = 0; n_s2g = 0; stab_err = 0; busy_err = 0;
        first_cmd_cyc = -1; s2g_rise_cyc = -1; retire_cyc = -1;
        g2s_hs_cyc = -1; q_hs_cyc = -1; last_done_cyc = -1;
        prev_stall = 1'b0;
    endtask

    task automatic run_insn(string tag, logic [2:0] op, bit pop, bit push,
                            logic [15:0] sb, logic [31:0] db, logic [15:0] y,
                            logic [15:0] x, logic [15:0] st, int gdly);
        logic [15:0] sa;
        logic [31:0] da;
        int          budget;
        exp_q.delete();
        if (op == 3'd1 && y != 0 && x != 0)
            for (int r = 0; r < int'(y); r++) begin
                sa = sb + 16'(r) * x;
                da = (db + 32'(r) * 32'(st)) * 32'd16;
                exp_q.push_back('{sa, da, x});
            end
        clear_obs();
        bus.store_queue_V_V_TDATA  = mk_insn(op, pop, push, sb, db, y, x, st);
        bus.store_queue_V_V_TVALID = 1'b1;
        budget = 0;
        while (q_hs_cyc < 0 && budget < 20) begin cycle(); budget++; end
        check({tag, "/accept"}, 64'(q_hs_cyc >= 0), 64'd1);
        if (pop) begin
            repeat (gdly) cycle();
            check({tag, "/cmd_before_token"}, 64'(first_cmd_cyc < 0), 64'd1);
            bus.g2s_dep_TVALID = 1'b1;
        end
        budget = 0;
        while (!(retired_cnt == exp_ret + 1 && !busy) && budget < 2000) begin
            cycle();
            budget++;
        end
        retire_cyc = cyc;
        exp_ret++;
        check({tag, "/timeout"}, 64'(budget < 2000), 64'd1);
        check({tag, "/retired"}, 64'(retired_cnt), 64'(exp_ret));
        check({tag, "/ncmd"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check({tag, "/cmd"}, got_q[i], exp_q[i]);
        check({tag, "/g2s_pops"}, 64'(n_g2s), 64'(pop));
        check({tag, "/s2g_pushes"}, 64'(n_s2g), 64'(push));
        check({tag, "/stall_stable"}, 64'(stab_err), 64'd0);
        check({tag, "/tready_busy"}, 64'(busy_err), 64'd0);
        if (exp_q.size() > 0) begin
            check({tag, "/cmd_latency"}, 64'(first_cmd_cyc),
                  64'((pop ? g2s_hs_cyc : q_hs_cyc) + 1));
            if (push)
                check({tag, "/s2g_latency"}, 64'(s2g_rise_cyc), 64'(last_done_cyc + 1));
            else
                check({tag, "/retire_latency"}, 64'(retire_cyc), 64'(last_done_cyc + 1));
        end
        cycle();
        check({tag, "/tready_after"}, 64'(bus.store_queue_V_V_TREADY), 64'd1);
    endtask

    task automatic check_reset_vals(string tag);
        check({tag, "/tready"}, 64'(bus.store_queue_V_V_TREADY), 64'd1);
        check({tag, "/cmd_valid"}, 64'(bus.cmd_valid), 64'd0);
        check({tag, "/cmd_fields"},
              {bus.cmd_sram_addr, bus.cmd_dram_addr, bus.cmd_len}, 64'd0);
        check({tag, "/g2s_ready"}, 64'(bus.g2s_dep_TREADY), 64'd0);
        check({tag, "/s2g_valid"}, 64'(bus.s2g_dep_TVALID), 64'd0);
        check({tag, "/busy"}, 64'(busy), 64'd0);
        check({tag, "/retired"}, 64'(retired_cnt), 64'd0);
    endtask

    initial begin
        logic [2:0] op;
        ap_rst = 1'b1;
        bus.store_queue_V_V_TDATA  = '0;
        bus.store_queue_V_V_TVALID = 1'b0;
        bus.g2s_dep_TVALID = 1'b0;
        bus.s2g_dep_TREADY = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.wr_done = 1'b0;
        rdy_mode = 0; dmin = 1; dmax = 3; s2g_rand = 1'b0;
        last_due = 0; exp_ret = '0;
        q_sent = 1'b0; g2s_taken = 1'b0;
        clear_obs();
        repeat (3) @(negedge ap_clk);
        check_reset_vals("reset");
        ap_rst = 1'b0;
        cycle();
        check_reset_vals("post_reset");

        run_insn("single", 3'd1, 0, 0, 16'd1, 32'd2, 16'd1, 16'd1, 16'd0, 0);
        run_insn("deps3", 3'd1, 1, 1, 16'd4, 32'd100, 16'd3, 16'd16, 16'd20, 5);
        rdy_mode = 1; s2g_rand = 1'b1;
        run_insn("stall3", 3'd1, 1, 1, 16'd4, 32'd100, 16'd3, 16'd16, 16'd20, 2);
        rdy_mode = 0; s2g_rand = 1'b0;
        run_insn("finish", 3'd3, 1, 1, 16'd7, 32'd9, 16'd2, 16'd2, 16'd2, 1);
        run_insn("y_zero", 3'd1, 0, 0, 16'd3, 32'd5, 16'd0, 16'd8, 16'd8, 0);
        run_insn("x_zero", 3'd1, 0, 1, 16'd3, 32'd5, 16'd2, 16'd0, 16'd8, 0);
        run_insn("wrap", 3'd1, 0, 0, 16'hFFFE, 32'h0FFF_FFFF, 16'd3, 16'd4, 16'h1000, 0);
        dmin = 1; dmax = 1;
        run_insn("done_overlap", 3'd1, 0, 1, 16'd10, 32'd20, 16'd4, 16'd3, 16'd5, 0);

        for (int n = 0; n < 24; n++) begin
            op = ($urandom_range(0, 9) < 8) ? 3'd1 : 3'($urandom_range(0, 4));
            rdy_mode = $urandom_range(0, 1);
            s2g_rand = 1'($urandom_range(0, 1));
            dmin = 1; dmax = $urandom_range(1, 6);
            run_insn("rand", op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     16'($urandom), $urandom, 16'($urandom_range(0, 5)),
                     ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom),
                     16'($urandom), $urandom_range(0, 3));
        end

        rdy_mode = 2; dmin = 1; dmax = 3; s2g_rand = 1'b0;
        clear_obs();
        bus.store_queue_V_V_TDATA  = mk_insn(3'd1, 0, 1, 16'd8, 32'd8, 16'd3, 16'd2, 16'd2);
        bus.store_queue_V_V_TVALID = 1'b1;
        cycle(); cycle(); cycle();
        check("rst_mid/in_issue", 64'(bus.cmd_valid), 64'd1);
        ap_rst = 1'b1;
        cycle();
        ap_rst = 1'b0;
        check_reset_vals("rst_mid");
        due_q.delete(); last_due = cyc; exp_ret = '0;
        rdy_mode = 0;
        run_insn("after_rst", 3'd1, 1, 1, 16'd2, 32'd3, 16'd2, 16'd5, 16'd7, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
